// File: rtl/led_pattern_seq_if.sv
// Control and LED-drive bundle for led_pattern_seq.
// Optional duty input present only when LED_PWM_EN is defined.
interface led_pattern_seq_if #(
  parameter int LED_NUM = 8
);
  logic               run;
  logic [1:0]         mode;
  logic [1:0]         speed;
  logic [LED_NUM-1:0] led_out;
  logic               step_pulse;
`ifdef LED_PWM_EN
  logic [3:0]         duty;

  modport master (output run, mode, speed, duty, input led_out, step_pulse);
  modport slave  (input run, mode, speed, duty, output led_out, step_pulse);
`else
  modport master (output run, mode, speed, input led_out, step_pulse);
  modport slave  (input run, mode, speed, output led_out, step_pulse);
`endif
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: prescaled step timer driving rotate / ping-pong / bar-fill patterns.
// Optional macro LED_PWM_EN adds a 16-level brightness gate on lit LEDs.
//
// dir state | meaning
// DIR_UP    | ping-pong lit bit moving toward MSB
// DIR_DOWN  | ping-pong lit bit moving toward bit0
module led_pattern_seq #(
  parameter int LED_NUM    = 8,
  parameter int CNT_MAX    = 24_999_999,
  parameter int ACTIVE_LOW = 1
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  led_pattern_seq_if.slave  bus
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0]      CNT_TC    = CW'(CNT_MAX);
  localparam logic [LED_NUM-1:0] PAT_START = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] LED_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         step_cnt_q, step_cnt_d;
  logic [LED_NUM-1:0] pattern_q, pattern_d;
  dir_e               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic               step_q, step_d;
  logic               step_pulse_q, step_pulse_d;
  logic [LED_NUM-1:0] led_out_q, led_out_d;
  logic [2:0]         step_tc;
  logic [LED_NUM-1:0] pat_next;
  dir_e               dir_next;
  logic [LED_NUM-1:0] lit;
`ifdef LED_PWM_EN
  logic [3:0]         pwm_cnt_q, pwm_cnt_d;
`endif

  // 2^speed - 1 in 3-bit arithmetic (speed 3 wraps 0 - 1 to 7)
  assign step_tc = (3'b001 << bus.speed) - 3'd1;

  always_comb begin
    pat_next = pattern_q;
    dir_next = dir_q;
    case (mode_q)
      MODE_LEFT:  pat_next = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
      MODE_RIGHT: pat_next = {pattern_q[0], pattern_q[LED_NUM-1:1]};
      MODE_PING: begin
        if (dir_q == DIR_UP) begin
          if (pattern_q[LED_NUM-1]) begin
            pat_next = pattern_q >> 1;
            dir_next = DIR_DOWN;
          end else begin
            pat_next = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            pat_next = pattern_q << 1;
            dir_next = DIR_UP;
          end else begin
            pat_next = pattern_q >> 1;
          end
        end
      end
      default:    pat_next = (&pattern_q) ? PAT_START : {pattern_q[LED_NUM-2:0], 1'b1};
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    step_cnt_d = step_cnt_q;
    pattern_d  = pattern_q;
    dir_d      = dir_q;
    mode_d     = bus.mode;
    step_d     = 1'b0;
    if (bus.mode != mode_q) begin
      cnt_d      = '0;
      step_cnt_d = '0;
      pattern_d  = PAT_START;
      dir_d      = DIR_UP;
    end else if (bus.run) begin
      if (cnt_q == CNT_TC) begin
        cnt_d = '0;
        if (step_cnt_q >= step_tc) begin
          step_cnt_d = '0;
          step_d     = 1'b1;
          pattern_d  = pat_next;
          dir_d      = dir_next;
        end else begin
          step_cnt_d = step_cnt_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

`ifdef LED_PWM_EN
  assign pwm_cnt_d = pwm_cnt_q + 4'd1;
  assign lit       = pattern_q & {LED_NUM{pwm_cnt_q < bus.duty}};
`else
  assign lit       = pattern_q;
`endif

  // Pulse trails the pattern update by one cycle so it lines up with led_out
  assign step_pulse_d = step_q;
  assign led_out_d    = (ACTIVE_LOW != 0) ? ~lit : lit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q        <= '0;
      step_cnt_q   <= '0;
      pattern_q    <= PAT_START;
      dir_q        <= DIR_UP;
      mode_q       <= MODE_LEFT;
      step_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      led_out_q    <= LED_OFF;
`ifdef LED_PWM_EN
      pwm_cnt_q    <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      step_cnt_q   <= step_cnt_d;
      pattern_q    <= pattern_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      step_q       <= step_d;
      step_pulse_q <= step_pulse_d;
      led_out_q    <= led_out_d;
`ifdef LED_PWM_EN
      pwm_cnt_q    <= pwm_cnt_d;
`endif
    end
  end

  assign bus.led_out    = led_out_q;
  assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq (LED_NUM=4, CNT_MAX=4, active-low).
module tb_led_pattern_seq;
  localparam int N       = 4;
  localparam int CNT_MAX = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  led_pattern_seq_if #(.LED_NUM(N)) bus ();

  led_pattern_seq #(.LED_NUM(N), .CNT_MAX(CNT_MAX), .ACTIVE_LOW(1)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] led;
  } exp_t;
  exp_t q[$];

  int m_mode, m_k, m_rc, m_ts;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Pattern as a function of steps taken since the mode was loaded
  function automatic logic [3:0] exp_pat(input int mode, input int k);
    logic [3:0] one;
    int idx, p;
    one = 4'b0001;
    idx = 0;
    case (mode)
      0: idx = k % N;
      1: idx = (N - (k % N)) % N;
      2: begin
        p   = k % (2*N - 2);
        idx = (p < N) ? p : (2*N - 2 - p);
      end
      default: return 4'((1 << ((k % N) + 1)) - 1);
    endcase
    return one << idx;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_rc = 0; m_ts = 0;
    q.delete();
  endtask

  // Predicts the coming edge from the inputs currently applied
  task automatic model_edge();
    exp_t e;
    if (int'(bus.mode) != m_mode) begin
      m_mode = int'(bus.mode); m_k = 0; m_rc = 0; m_ts = 0;
    end else if (bus.run) begin
      if (m_rc == CNT_MAX) begin
        m_rc = 0;
        m_ts++;
        if (m_ts >= (1 << bus.speed)) begin
          m_ts  = 0;
          m_k++;
          e.cyc = cyc + 2;
          e.led = ~exp_pat(m_mode, m_k);
          q.push_back(e);
        end
      end else begin
        m_rc++;
      end
    end
  endtask

  task automatic step_edge();
    model_edge();
    @(posedge sys_clk);
    #1;
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_step_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.step_pulse) begin
        if (q.size() == 0) begin
          chk("unexpected_step_pulse", 1, 0);
        end else begin
          chk("step_cycle", cyc, q[0].cyc);
          chk("step_led", int'(bus.led_out), int'(q[0].led));
          void'(q.pop_front());
        end
      end
    end
  end

`ifdef LED_PWM_EN
  initial begin
    int lit_cnt;
    bus.run = 1'b0; bus.mode = 2'b00; bus.speed = 2'b00; bus.duty = 4'd4;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (3) step_edge();
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step_edge();
      if (bus.led_out[0] == 1'b0) lit_cnt++;
      chk("pwm_unlit_leds", int'(bus.led_out[3:1]), 7);
    end
    chk("pwm_duty4", lit_cnt, 4);
    bus.duty = 4'd0;
    repeat (3) step_edge();
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step_edge();
      if (bus.led_out != 4'b1111) lit_cnt++;
    end
    chk("pwm_duty0", lit_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
`else
  initial begin
    int guard;
    bus.run = 1'b1; bus.mode = 2'b00; bus.speed = 2'b00;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_led", int'(bus.led_out), 4'b1111);
    chk("reset_pulse", int'(bus.step_pulse), 0);
    sys_rst_n = 1'b1;
    step_edge();
    chk("first_led", int'(bus.led_out), 4'b1110);
    repeat (20) step_edge();

    // Rotate-left until pattern 0100, then switch to rotate-right
    guard = 0;
    while (m_k % N != 2 && guard < 50) begin step_edge(); guard++; end
    chk("reach_0100", m_k % N, 2);
    bus.mode = 2'b01;
    step_edge();
    step_edge();
    chk("mode_switch_led", int'(bus.led_out), 4'b1110);
    repeat (12) step_edge();

    // Slow speed with a 13-cycle pause mid-interval
    bus.mode = 2'b00; bus.speed = 2'd2;
    repeat (30) step_edge();
    bus.run = 1'b0;
    repeat (13) step_edge();
    bus.run = 1'b1;
    repeat (45) step_edge();

    // Ping-pong
    bus.mode = 2'b10; bus.speed = 2'd0;
    repeat (60) step_edge();

    // Bar-fill to 0111, then asynchronous reset between edges
    bus.mode = 2'b11;
    guard = 0;
    step_edge();
    while (!(m_mode == 3 && m_k == 2) && guard < 100) begin step_edge(); guard++; end
    chk("reach_0111", m_k, 2);
    step_edge();
    chk("bar_before_rst", int'(bus.led_out), 4'b1000);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_led", int'(bus.led_out), 4'b1111);
    chk("async_rst_pulse", int'(bus.step_pulse), 0);
    model_reset();
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    step_edge();
    chk("resume_bit0", int'(bus.led_out), 4'b1110);
    repeat (30) step_edge();

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) bus.speed = 2'($urandom_range(0, 3));
      bus.run = ($urandom_range(0, 7) != 0);
      step_edge();
    end

    bus.run = 1'b0;
    repeat (4) step_edge();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
`endif
endmodule

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 SHALL have parameter LED_NUM, default 8, number of LEDs (legal range 2..32).
REQ-002 SHALL have parameter CNT_MAX, default 24_999_999, prescaler terminal count (base tick period CNT_MAX+1 cycles).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 = lit LED driven 0, 0 = lit LED driven 1.
REQ-004 SHALL have ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = sequence advances; 0 = pause.
- mode  in  2  00 shift-left, 01 shift-right, 10 ping-pong, 11 bar-fill.
- speed  in  2  one step every 2^speed base ticks.
- led_out  out  LED_NUM  registered LED drive, polarity per ACTIVE_LOW.
- step_pulse  out  1  one-cycle strobe, high in the cycle the new pattern first appears on led_out.

Function
REQ-005 Prescaler SHALL count 0..CNT_MAX with width $clog2(CNT_MAX+1), wrap to 0, and produce tick when cnt==CNT_MAX and run==1.
REQ-006 With run==0, prescaler, step counter, pattern and direction SHALL hold; led_out SHALL keep showing the held pattern.
REQ-007 A 3-bit step counter SHALL advance on tick; a step SHALL occur on tick when step_cnt==(2^speed)-1, and step_cnt SHALL then clear.
REQ-008 A speed change SHALL take effect at the next tick; if step_cnt already ≥ the new terminal, the step SHALL occur on that tick.
REQ-009 Pattern register (LED_NUM bits) start values: mode 00/01/11 = bit0 set; mode 10 = bit0 set, direction up.
REQ-010 Mode 00: pattern rotates left one bit per step; MSB wraps to bit0.
REQ-011 Mode 01: pattern rotates right one bit per step; bit0 wraps to MSB.
REQ-012 Mode 10: single lit bit moves up until MSB, then down until bit0; each end SHALL be shown exactly one step (no repeat at the ends); period 2*(LED_NUM-1) steps.
REQ-013 Mode 11: pattern = (pattern<<1)|1 per step; when all ones, next step SHALL return to bit0-only; period LED_NUM steps.
REQ-014 Mode SHALL be registered each cycle; when mode differs from the registered value, the next edge SHALL load the new mode's start value and clear prescaler and step counter; no step that cycle.
REQ-015 led_out SHALL be registered from pattern, one cycle behind it; step_pulse SHALL be registered, aligned with the first led_out cycle of the new pattern.
REQ-016 Exactly one lit LED in modes 00/01/10 at all times after reset.

Reset
REQ-017 On sys_rst_n low, asynchronously: cnt=0, step_cnt=0, pattern=bit0 only, direction=up, mode register=00, step_pulse=0, led_out=all LEDs unlit (all 1 if ACTIVE_LOW=1, else all 0).
REQ-018 First clock after reset release SHALL drive led_out with bit0 lit (PWM gating applied if enabled); the first step SHALL occur (CNT_MAX+1)*2^speed cycles after release.
REQ-019 Reset asserted mid-sequence SHALL override all activity on the same instant, whatever run/mode are.

Configuration
REQ-020 Macro LED_PWM_EN: when defined, SHALL add input duty [3:0] and a free-running 4-bit pwm counter (reset 0); a lit LED SHALL be driven lit only while pwm_cnt < duty (duty 0 = dark, 15 = 15/16 on); unlit LEDs are unaffected.
REQ-021 Without LED_PWM_EN: no duty port, no pwm counter; lit LEDs SHALL be driven lit continuously.
REQ-022 Pwm counter SHALL keep running when run==0.

Verification (LED_NUM=4, CNT_MAX=4, ACTIVE_LOW=1, speed=0 unless stated)
REQ-023 Reset release, mode 00, run=1 -> led_out 1111, then 1110; steps every 5 cycles: 1101, 1011, 0111, 1110; step_pulse high one cycle per step.
REQ-024 Mode 10 for 8 steps -> lit index 0,1,2,3,2,1,0,1,2; mode 11 -> 1110,1100,1000,0000,1110.
REQ-025 speed=2 -> steps every 20 cycles; run=0 for 13 cycles mid-interval -> the next step is delayed by exactly 13 cycles, and the pattern is unchanged.
REQ-026 Switch mode 00->01 while pattern is 0100 -> next cycle pattern 0001, no step_pulse; first 01-mode step after 5 cycles gives 1000.
REQ-027 Assert sys_rst_n low asynchronously between edges while in mode 11 with pattern 0111 -> led_out 1111 immediately; resume from bit0.
REQ-028 LED_PWM_EN, duty=4 -> lit LED driven low exactly 4 of every 16 cycles; duty=0 -> led_out stays 1111.
